usb_rx_sync_controller: RTL and testbench

Receive-side sequencer for the full-speed bit clock recovery path. It consumes the per-bit sample strobe and the synchronized line state, qualifies bus idle, and hunts and validates the SYNC pattern. It then NRZI-decodes and un-stuffs the packet body, detects EOP, and reports packet framing (active, end, error) to the downstream SIE byte assembler.

---
 rtl/usb_rx_sync_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_usb_rx_sync_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_sync_controller.sv
// Full-speed USB receive sequencer: qualifies bus idle, hunts SYNC, NRZI-decodes and
// un-stuffs the packet body, and frames EOP/errors. Everything advances on bit_strobe samples.
module usb_rx_sync_controller #(
  parameter int unsigned IDLE_J_MIN     = 2,
  parameter int unsigned SYNC_MIN_ZEROS = 5,
  parameter int unsigned EOP_SE0_MAX    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_strobe,
  input  logic [1:0] line_state_sync,
  input  logic       rx_enable,
  output logic       rx_active,
  output logic       rx_bit,
  output logic       rx_bit_valid,
  output logic       eop_detected,
  output logic       rx_error,
  output logic [1:0] err_code,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_EOP    = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SYNC  = 2'd1,
    ERR_STUFF = 2'd2,
    ERR_LINE  = 2'd3
  } err_e;

  localparam int JW = (IDLE_J_MIN < 1) ? 1 : $clog2(IDLE_J_MIN + 1);
  localparam int SW = $clog2(EOP_SE0_MAX + 2);
  localparam logic [JW-1:0] J_MIN    = JW'(IDLE_J_MIN);
  localparam logic [3:0]    ZERO_MIN = 4'(SYNC_MIN_ZEROS);
  localparam logic [SW-1:0] SE0_MAX  = SW'(EOP_SE0_MAX);

  state_e        state_q, state_d;
  logic [JW-1:0] j_cnt_q, j_cnt_d;
  logic [3:0]    zero_cnt_q, zero_cnt_d;
  logic [2:0]    ones_cnt_q, ones_cnt_d;
  logic [SW-1:0] se0_cnt_q, se0_cnt_d;
  line_e         prev_q, prev_d;
  err_e          err_code_q, err_code_d, err_cause;
  logic          rx_active_d, rx_bit_d, rx_bit_valid_d, eop_d, err_d, go_err;

  line_e ls;
  logic  is_jk;
  logic  dbit;

  assign ls    = line_e'(line_state_sync);
  assign is_jk = (ls == LS_J) || (ls == LS_K);
  // NRZI: an unchanged line level decodes as 1, a transition as 0.
  assign dbit  = (ls == prev_q);

  assign state    = state_q;
  assign err_code = err_code_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d        = state_q;
    j_cnt_d        = j_cnt_q;
    zero_cnt_d     = zero_cnt_q;
    ones_cnt_d     = ones_cnt_q;
    se0_cnt_d      = se0_cnt_q;
    prev_d         = prev_q;
    rx_bit_d       = rx_bit;
    rx_bit_valid_d = 1'b0;
    eop_d          = 1'b0;
    err_d          = 1'b0;
    err_code_d     = err_code_q;
    go_err         = 1'b0;
    err_cause      = ERR_NONE;

    if (!rx_enable) begin
      state_d    = ST_IDLE;
      j_cnt_d    = '0;
      zero_cnt_d = '0;
      ones_cnt_d = '0;
      se0_cnt_d  = '0;
      prev_d     = LS_J;
    end else if (bit_strobe) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ls == LS_J) begin
            if (j_cnt_q < J_MIN) j_cnt_d = j_cnt_q + 1'b1;
          end else if ((ls == LS_K) && (j_cnt_q >= J_MIN)) begin
            // The SOP K is itself the first decoded zero of SYNC.
            state_d    = ST_SYNC;
            prev_d     = LS_K;
            zero_cnt_d = 4'd1;
            j_cnt_d    = '0;
          end else begin
            j_cnt_d = '0;
          end
        end

        ST_SYNC: begin
          if (!is_jk) begin
            go_err    = 1'b1;
            err_cause = ERR_SYNC;
          end else begin
            prev_d = ls;
            if (!dbit) begin
              if (zero_cnt_q != 4'hF) zero_cnt_d = zero_cnt_q + 4'd1;
            end else if (zero_cnt_q >= ZERO_MIN) begin
              // The terminating SYNC one counts toward the first stuffing run.
              state_d    = ST_ACTIVE;
              ones_cnt_d = 3'd1;
            end else begin
              go_err    = 1'b1;
              err_cause = ERR_SYNC;
            end
          end
        end

        ST_ACTIVE: begin
          if (ls == LS_SE0) begin
            state_d   = ST_EOP;
            se0_cnt_d = SW'(1);
          end else if (ls == LS_SE1) begin
            go_err    = 1'b1;
            err_cause = ERR_LINE;
          end else begin
            prev_d = ls;
            if (ones_cnt_q == 3'd6) begin
              if (dbit) begin
                go_err    = 1'b1;
                err_cause = ERR_STUFF;
              end else begin
                ones_cnt_d = '0;
              end
            end else begin
              rx_bit_d       = dbit;
              rx_bit_valid_d = 1'b1;
              ones_cnt_d     = dbit ? ones_cnt_q + 3'd1 : 3'd0;
            end
          end
        end

        ST_EOP: begin
          if (ls == LS_SE0) begin
            if (se0_cnt_q >= SE0_MAX) begin
              go_err    = 1'b1;
              err_cause = ERR_LINE;
            end else begin
              se0_cnt_d = se0_cnt_q + 1'b1;
            end
          end else if (ls == LS_J) begin
            eop_d     = 1'b1;
            state_d   = ST_IDLE;
            j_cnt_d   = JW'(1);
            se0_cnt_d = '0;
          end else begin
            go_err    = 1'b1;
            err_cause = ERR_LINE;
          end
        end

        ST_ERROR: begin
          // Reuse j_cnt for the recovery run; leaving with a full count makes the next K an SOP.
          if (ls == LS_J) begin
            if (j_cnt_q >= J_MIN - 1'b1) begin
              state_d = ST_IDLE;
              j_cnt_d = J_MIN;
            end else begin
              j_cnt_d = j_cnt_q + 1'b1;
            end
          end else begin
            j_cnt_d = '0;
          end
        end

        default: state_d = ST_IDLE;
      endcase

      if (go_err) begin
        state_d    = ST_ERROR;
        j_cnt_d    = '0;
        err_d      = 1'b1;
        err_code_d = err_cause;
      end
    end

    rx_active_d = (state_d == ST_ACTIVE) || (state_d == ST_EOP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      j_cnt_q      <= '0;
      zero_cnt_q   <= '0;
      ones_cnt_q   <= '0;
      se0_cnt_q    <= '0;
      prev_q       <= LS_J;
      err_code_q   <= ERR_NONE;
      rx_active    <= 1'b0;
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
      eop_detected <= 1'b0;
      rx_error     <= 1'b0;
    end else begin
      state_q      <= state_d;
      j_cnt_q      <= j_cnt_d;
      zero_cnt_q   <= zero_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      se0_cnt_q    <= se0_cnt_d;
      prev_q       <= prev_d;
      err_code_q   <= err_code_d;
      rx_active    <= rx_active_d;
      rx_bit       <= rx_bit_d;
      rx_bit_valid <= rx_bit_valid_d;
      eop_detected <= eop_d;
      rx_error     <= err_d;
    end
  end

endmodule

// File: tb/tb_usb_rx_sync_controller.sv
// Self-checking bench for usb_rx_sync_controller: directed packets plus randomized line
// traffic, compared every cycle against a per-strobe behavioural model of the receiver.
module tb_usb_rx_sync_controller;

  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;
  localparam int IDLE_J_MIN = 2, SYNC_MIN_ZEROS = 5, EOP_SE0_MAX = 3;
  localparam int M_IDLE = 0, M_SYNC = 1, M_ACTIVE = 2, M_EOP = 3, M_ERROR = 4;

  logic       clk, rst, bit_strobe, rx_enable;
  logic [1:0] line_state_sync;
  logic       rx_active, rx_bit, rx_bit_valid, eop_detected, rx_error;
  logic [1:0] err_code;
  logic [2:0] state;

  usb_rx_sync_controller dut (
    .clk(clk), .rst(rst), .bit_strobe(bit_strobe), .line_state_sync(line_state_sync),
    .rx_enable(rx_enable), .rx_active(rx_active), .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid),
    .eop_detected(eop_detected), .rx_error(rx_error), .err_code(err_code), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected outputs after the next clock edge.
  int         mode, m_j, m_zero, m_ones, m_se0;
  logic [1:0] m_prev;
  logic       e_active, e_bit, e_valid, e_eop, e_err;
  logic [1:0] e_code;
  int         e_state;

  task automatic model_step(input logic r, input logic en, input logic stb, input logic [1:0] s);
    int  fail;
    bit  jk, d;
    e_valid = 0; e_eop = 0; e_err = 0;
    fail = 0;
    if (r) begin
      mode = M_IDLE; m_j = 0; m_zero = 0; m_ones = 0; m_se0 = 0; m_prev = J;
      e_bit = 0; e_code = 0;
    end else if (!en) begin
      mode = M_IDLE; m_j = 0; m_zero = 0; m_ones = 0; m_se0 = 0; m_prev = J;
    end else if (stb) begin
      jk = (s == J) || (s == K);
      d  = (s == m_prev);
      case (mode)
        M_IDLE:
          if (s == J) m_j = (m_j + 1 > IDLE_J_MIN) ? IDLE_J_MIN : m_j + 1;
          else if (s == K && m_j >= IDLE_J_MIN) begin
            mode = M_SYNC; m_prev = K; m_zero = 1;
          end else m_j = 0;
        M_SYNC:
          if (!jk) fail = 1;
          else begin
            m_prev = s;
            if (!d) m_zero = (m_zero < 15) ? m_zero + 1 : 15;
            else if (m_zero >= SYNC_MIN_ZEROS) begin mode = M_ACTIVE; m_ones = 1; end
            else fail = 1;
          end
        M_ACTIVE:
          if (s == SE0) begin mode = M_EOP; m_se0 = 1; end
          else if (s == SE1) fail = 3;
          else begin
            m_prev = s;
            if (m_ones == 6) begin
              if (d) fail = 2; else m_ones = 0;
            end else begin
              e_valid = 1; e_bit = d; m_ones = d ? m_ones + 1 : 0;
            end
          end
        M_EOP:
          if (s == SE0) begin
            m_se0++;
            if (m_se0 > EOP_SE0_MAX) fail = 3;
          end else if (s == J) begin
            e_eop = 1; mode = M_IDLE; m_j = 1;
          end else fail = 3;
        default: // M_ERROR
          if (s == J) begin
            m_j++;
            if (m_j >= IDLE_J_MIN) begin mode = M_IDLE; m_j = IDLE_J_MIN; end
          end else m_j = 0;
      endcase
      if (fail != 0) begin
        mode = M_ERROR; m_j = 0; e_err = 1; e_code = 2'(fail);
      end
    end
    e_state  = mode;
    e_active = (mode == M_ACTIVE) || (mode == M_EOP);
  endtask

  // Compare process plus running totals used by directed checks.
  bit          cmp_en = 0;
  int          tot_valid = 0, tot_eop = 0, tot_err = 0, tot_active = 0;
  logic [15:0] cap = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        check("state", 32'(state), 32'(e_state));
        check("rx_active", 32'(rx_active), 32'(e_active));
        check("rx_bit", 32'(rx_bit), 32'(e_bit));
        check("rx_bit_valid", 32'(rx_bit_valid), 32'(e_valid));
        check("eop_detected", 32'(eop_detected), 32'(e_eop));
        check("rx_error", 32'(rx_error), 32'(e_err));
        check("err_code", 32'(err_code), 32'(e_code));
        if (rx_bit_valid) begin
          tot_valid++;
          cap = {rx_bit, cap[15:1]};
        end
        if (eop_detected) tot_eop++;
        if (rx_error) tot_err++;
        if (rx_active) tot_active++;
      end
    end
  end

  // Stimulus: inputs change on the falling edge, one clock per tick.
  task automatic tick(input logic r, input logic en, input logic stb, input logic [1:0] ls);
    rst = r; rx_enable = en; bit_strobe = stb; line_state_sync = ls;
    model_step(r, en, stb, ls);
    cmp_en = 1;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [1:0] ls);
    tick(1'b0, 1'b1, 1'b1, ls);
    repeat ($urandom_range(0, 3)) tick(1'b0, 1'b1, 1'b0, 2'($urandom));
  endtask

  task automatic send_j(input int n);
    repeat (n) strobe(J);
  endtask

  task automatic send_sync();
    logic [1:0] seq [8] = '{K, J, K, J, K, J, K, K};
    for (int i = 0; i < 8; i++) strobe(seq[i]);
  endtask

  // NRZI-encode nbits LSB-first; the SYNC's final K/one starts both the level and the ones run.
  task automatic send_body(input logic [31:0] data, input int nbits, input bit do_stuff);
    logic [1:0] lvl = K;
    int ones = 1;
    for (int i = 0; i < nbits; i++) begin
      if (!data[i]) lvl = ~lvl;
      strobe(lvl);
      ones = data[i] ? ones + 1 : 0;
      if (do_stuff && ones == 6) begin
        lvl = ~lvl;
        strobe(lvl);
        ones = 0;
      end
    end
  endtask

  // n SE0 samples then a J with no trailing gap.
  task automatic send_eop(input int n);
    repeat (n) strobe(SE0);
    tick(1'b0, 1'b1, 1'b1, J);
  endtask

  int v0, e0, r0, a0;

  task automatic snap();
    v0 = tot_valid; e0 = tot_eop; r0 = tot_err; a0 = tot_active;
  endtask

  initial begin
    rst = 1; rx_enable = 1; bit_strobe = 0; line_state_sync = J;
    tick(1'b1, 1'b1, 1'b0, J);
    tick(1'b1, 1'b1, 1'b0, J);
    check("reset_state", 32'(state), 0);
    check("reset_err_code", 32'(err_code), 0);

    // Clean packet 0xA5
    snap();
    send_j(4); send_sync(); send_body(32'hA5, 8, 1); send_eop(2);
    check("a5_eop_pulse", 32'(eop_detected), 1);
    check("a5_active_fall", 32'(rx_active), 0);
    check("a5_bits", 32'(tot_valid - v0), 8);
    check("a5_data", 32'(cap[15:8]), 32'hA5);
    check("a5_eop_cnt", 32'(tot_eop - e0), 1);
    check("a5_no_err", 32'(tot_err - r0), 0);

    // Stuffing: 0xFF, 0x01 with a stuff bit after six ones
    snap();
    send_j(2); send_sync(); send_body(32'h01FF, 16, 1); send_eop(2);
    check("stuff_bits", 32'(tot_valid - v0), 16);
    check("stuff_data", 32'(cap), 32'h01FF);
    check("stuff_eop_cnt", 32'(tot_eop - e0), 1);

    // Missing stuff bit
    snap();
    send_j(2); send_sync(); send_body(32'hFF, 8, 0);
    check("nostuff_code", 32'(err_code), 2);
    check("nostuff_err_cnt", 32'(tot_err - r0), 1);
    check("nostuff_active", 32'(rx_active), 0);
    check("nostuff_bits", 32'(tot_valid - v0), 5);
    send_j(2);
    check("nostuff_recover", 32'(state), 0);

    // Short SYNC, then a good packet
    snap();
    strobe(J); strobe(J); strobe(K); strobe(J); strobe(K); strobe(K);
    check("short_sync_code", 32'(err_code), 1);
    check("short_sync_err_cnt", 32'(tot_err - r0), 1);
    check("short_sync_no_active", 32'(tot_active - a0), 0);
    snap();
    send_j(2); send_sync(); send_body(32'hA5, 8, 1); send_eop(1);
    check("resync_active", 32'(tot_active - a0 > 0), 1);
    check("resync_data", 32'(cap[15:8]), 32'hA5);

    // Long SE0
    snap();
    send_j(2); send_sync(); send_body(32'h5A, 8, 1);
    repeat (4) strobe(SE0);
    check("long_se0_code", 32'(err_code), 3);
    check("long_se0_err_cnt", 32'(tot_err - r0), 1);
    check("long_se0_no_eop", 32'(tot_eop - e0), 0);
    send_j(2);
    check("long_se0_recover", 32'(state), 0);

    // rx_enable drop mid-byte
    snap();
    send_j(2); send_sync(); send_body(32'h5A, 4, 1);
    tick(1'b0, 1'b0, 1'b0, J);
    check("drop_state", 32'(state), 0);
    check("drop_active", 32'(rx_active), 0);
    check("drop_no_pulse", 32'({rx_bit_valid, eop_detected, rx_error}), 0);
    send_j(2); send_sync(); send_body(32'h3C, 8, 1); send_eop(2);
    check("drop_reenable_data", 32'(cap[15:8]), 32'h3C);
    check("drop_no_err", 32'(tot_err - r0), 0);

    // Reset mid-byte
    snap();
    send_j(2); send_sync(); send_body(32'hC3, 4, 1);
    tick(1'b1, 1'b1, 1'b1, K);
    tick(1'b1, 1'b0, 1'b0, J);
    check("rst_state", 32'(state), 0);
    check("rst_outputs", 32'({rx_active, rx_bit, rx_bit_valid, eop_detected, rx_error, err_code}), 0);
    tick(1'b0, 1'b1, 1'b0, J);
    check("rst_no_pulse", 32'((tot_eop - e0) + (tot_err - r0)), 0);

    // Randomized traffic
    for (int it = 0; it < 120; it++) begin
      int r = $urandom_range(0, 9);
      send_j($urandom_range(0, 3));
      if (r < 6) begin
        int nse = $urandom_range(0, 4);
        send_sync();
        send_body($urandom, $urandom_range(1, 24), ($urandom_range(0, 4) != 0));
        if (nse > 0) send_eop(nse);
      end else if (r == 6) begin
        tick(1'b0, 1'b0, 1'($urandom), 2'($urandom));
      end else if (r == 7) begin
        repeat (10) strobe(2'($urandom));
      end else if (r == 8) begin
        tick(1'b1, 1'($urandom), 1'($urandom), 2'($urandom));
      end else begin
        repeat (8) strobe($urandom_range(0, 1) ? J : K);
      end
    end
    repeat (4) tick(1'b0, 1'b1, 1'b0, J);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
